// File: rtl/sao_stat_accum.sv
// SAO edge-offset statistics engine: classifies BLK x BLK tiles, accumulates per-category
// diff sums/counts for one CTB and drains them as a stream. Band stats under `SAO_BO_STAT_EN.
module sao_stat_accum #(
    parameter int BIT_DEPTH = 8,
    parameter int BLK       = 4,
    parameter int DIFF_CLIP = 4,
    parameter int SUM_W     = 18,
    parameter int CNT_W     = 13
) (
    input  logic                                      clk,
    input  logic                                      arst_n,
    input  logic                                      start,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic                                      in_last,
    input  logic [BLK*BLK-1:0]                        pix_mask,
    input  logic [0:BLK-1][0:BLK-1][BIT_DEPTH-1:0]    rec_l,
    input  logic [0:BLK-1][0:BLK-1][BIT_DEPTH-1:0]    rec_m,
    input  logic [0:BLK-1][0:BLK-1][BIT_DEPTH-1:0]    rec_r,
    input  logic [0:BLK-1][0:BLK-1][BIT_DEPTH-1:0]    org_m,
    output logic                                      st_valid,
    input  logic                                      st_ready,
    output logic [5:0]                                st_cat,
    output logic signed [SUM_W-1:0]                   st_sum,
    output logic [CNT_W-1:0]                          st_cnt,
    output logic                                      st_last,
    output logic                                      busy
);

    // Handshake: a beat moves on in_valid && in_ready; a result moves on st_valid && st_ready,
    // and st_* hold stable while st_valid is high and st_ready is low.

    localparam int NPIX = BLK * BLK;
    localparam int DW   = DIFF_CLIP + 1;
    localparam int TSW  = DW + $clog2(NPIX) + 1;
    localparam int TCW  = $clog2(NPIX + 1);
`ifdef SAO_BO_STAT_EN
    localparam int NCAT = 36;
`else
    localparam int NCAT = 4;
`endif
    localparam logic signed [BIT_DEPTH:0] DMAX = (BIT_DEPTH+1)'((2 ** DIFF_CLIP) - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;

    state_t state;
    logic   flush_cnt;

    // Stage 0 (combinational classification)
    logic [2:0]                 cat_c  [NPIX];
    logic signed [DW-1:0]       diff_c [NPIX];
    logic [2:0]                 ep;
    logic signed [BIT_DEPTH:0]  df;

    // Stage 1 registers
    logic                       s1_v;
    logic [2:0]                 s1_cat  [NPIX];
    logic signed [DW-1:0]       s1_diff [NPIX];
`ifdef SAO_BO_STAT_EN
    logic [4:0]                 s1_band [NPIX];
    logic                       s1_ben  [NPIX];
`endif

    logic signed [TSW-1:0]      tile_sum [NCAT];
    logic [TCW-1:0]             tile_cnt [NCAT];
    logic signed [SUM_W-1:0]    acc_sum  [NCAT];
    logic [CNT_W-1:0]           acc_cnt  [NCAT];
    logic signed [SUM_W-1:0]    nxt_sum;
    logic [CNT_W-1:0]           nxt_cnt;

    function automatic logic signed [SUM_W-1:0] sat_sum(input logic signed [SUM_W-1:0] a,
                                                        input logic signed [TSW-1:0]   b);
        logic [SUM_W:0] s;
        s = {a[SUM_W-1], a} + {{(SUM_W+1-TSW){b[TSW-1]}}, b};
        if (s[SUM_W] != s[SUM_W-1])
            return s[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
        return s[SUM_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] a,
                                                 input logic [TCW-1:0]   b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W+1-TCW){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // ep = (sign_l + 1) + (sign_r + 1), so ep 0..4 corresponds to edge sum -2..+2
    always_comb begin
        ep = '0;
        df = '0;
        for (int i = 0; i < BLK; i++) begin
            for (int j = 0; j < BLK; j++) begin
                ep = ((rec_m[i][j] > rec_l[i][j]) ? 3'd2 : (rec_m[i][j] < rec_l[i][j]) ? 3'd0 : 3'd1)
                   + ((rec_m[i][j] > rec_r[i][j]) ? 3'd2 : (rec_m[i][j] < rec_r[i][j]) ? 3'd0 : 3'd1);
                case (ep)
                    3'd0:    cat_c[i*BLK+j] = 3'd1;
                    3'd1:    cat_c[i*BLK+j] = 3'd2;
                    3'd3:    cat_c[i*BLK+j] = 3'd3;
                    3'd4:    cat_c[i*BLK+j] = 3'd4;
                    default: cat_c[i*BLK+j] = 3'd0;
                endcase
                if (!pix_mask[i*BLK+j])
                    cat_c[i*BLK+j] = 3'd0;
                df = $signed({1'b0, org_m[i][j]}) - $signed({1'b0, rec_m[i][j]});
                if (df > DMAX)
                    df = DMAX;
                else if (df < -DMAX)
                    df = -DMAX;
                diff_c[i*BLK+j] = df[DW-1:0];
            end
        end
    end

    // Per-category reduction of the registered stage-1 pixels
    always_comb begin
        for (int c = 0; c < NCAT; c++) begin
            tile_sum[c] = '0;
            tile_cnt[c] = '0;
        end
        for (int p = 0; p < NPIX; p++) begin
            for (int c = 0; c < 4; c++) begin
                if (s1_cat[p] == 3'(c + 1)) begin
                    tile_sum[c] = tile_sum[c] + TSW'(s1_diff[p]);
                    tile_cnt[c] = tile_cnt[c] + TCW'(1);
                end
            end
`ifdef SAO_BO_STAT_EN
            for (int b = 0; b < 32; b++) begin
                if (s1_ben[p] && s1_band[p] == 5'(b)) begin
                    tile_sum[4+b] = tile_sum[4+b] + TSW'(s1_diff[p]);
                    tile_cnt[4+b] = tile_cnt[4+b] + TCW'(1);
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1_v <= 1'b0;
            for (int p = 0; p < NPIX; p++) begin
                s1_cat[p]  <= '0;
                s1_diff[p] <= '0;
`ifdef SAO_BO_STAT_EN
                s1_band[p] <= '0;
                s1_ben[p]  <= 1'b0;
`endif
            end
            for (int c = 0; c < NCAT; c++) begin
                acc_sum[c] <= '0;
                acc_cnt[c] <= '0;
            end
        end else if (start) begin
            s1_v <= 1'b0;
            for (int c = 0; c < NCAT; c++) begin
                acc_sum[c] <= '0;
                acc_cnt[c] <= '0;
            end
        end else begin
            s1_v <= in_valid && in_ready;
            for (int p = 0; p < NPIX; p++) begin
                s1_cat[p]  <= cat_c[p];
                s1_diff[p] <= diff_c[p];
`ifdef SAO_BO_STAT_EN
                s1_band[p] <= rec_m[p/BLK][p%BLK][BIT_DEPTH-1 -: 5];
                s1_ben[p]  <= pix_mask[p];
`endif
            end
            if (s1_v) begin
                for (int c = 0; c < NCAT; c++) begin
                    acc_sum[c] <= sat_sum(acc_sum[c], tile_sum[c]);
                    acc_cnt[c] <= sat_cnt(acc_cnt[c], tile_cnt[c]);
                end
            end
        end
    end

    // Entry for index st_cat+1: in FLUSH st_cat is 0, so this is the first result
    always_comb begin
        nxt_sum = '0;
        nxt_cnt = '0;
        for (int c = 0; c < NCAT; c++) begin
            if (st_cat == 6'(c)) begin
                nxt_sum = acc_sum[c];
                nxt_cnt = acc_cnt[c];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            flush_cnt <= 1'b0;
            in_ready  <= 1'b0;
            st_valid  <= 1'b0;
            st_last   <= 1'b0;
            st_cat    <= '0;
            st_sum    <= '0;
            st_cnt    <= '0;
            busy      <= 1'b0;
        end else if (start) begin
            state     <= ACCUM;
            flush_cnt <= 1'b0;
            in_ready  <= 1'b1;
            st_valid  <= 1'b0;
            st_last   <= 1'b0;
            st_cat    <= '0;
            st_sum    <= '0;
            st_cnt    <= '0;
            busy      <= 1'b1;
        end else begin
            case (state)
                IDLE: ;
                ACCUM: begin
                    if (in_valid && in_ready && in_last) begin
                        state     <= FLUSH;
                        in_ready  <= 1'b0;
                        flush_cnt <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt) begin
                        state    <= DRAIN;
                        st_valid <= 1'b1;
                        st_cat   <= 6'd1;
                        st_sum   <= nxt_sum;
                        st_cnt   <= nxt_cnt;
                        st_last  <= 1'b0;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (st_ready) begin
                        if (st_cat == 6'(NCAT)) begin
                            state    <= IDLE;
                            st_valid <= 1'b0;
                            st_last  <= 1'b0;
                            st_cat   <= '0;
                            st_sum   <= '0;
                            st_cnt   <= '0;
                            busy     <= 1'b0;
                        end else begin
                            st_cat  <= st_cat + 6'd1;
                            st_sum  <= nxt_sum;
                            st_cnt  <= nxt_cnt;
                            st_last <= (st_cat + 6'd1 == 6'(NCAT));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
